// File: rtl/get_decode.sv
// Receive-side decoder: classifies 32-bit int words into my_pkg::get_e codes,
// holds one result for a valid/ready consumer and keeps saturating class counts.
package my_pkg;
    typedef enum int {
        Get0       = 0,
        Get1       = 1,
        Get2       = 2,
        Get3       = 3,
        GetDefault = 100
    } get_e;
endpackage

module get_decode #(
    parameter my_pkg::get_e ExpectWhat  = my_pkg::Get0,
    parameter int           CntW        = 16,
    parameter bit           StopOnError = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output my_pkg::get_e       out_code,
    output logic               out_invalid,
    output logic [CntW-1:0]    match_cnt,
    output logic [CntW-1:0]    invalid_cnt,
    output logic               locked,
    input  logic               clear
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL   = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e       state;
    state_e       state_nxt;
    logic         alive;
    logic         vld_p1;
    logic         vld_nxt;
    logic         accept;
    logic         pop;
    logic         lock_event;
    my_pkg::get_e dec_code;
    logic         dec_invalid;

    function automatic my_pkg::get_e decode_code(input logic signed [31:0] word);
        case (word)
            32'sd0:  return my_pkg::Get0;
            32'sd1:  return my_pkg::Get1;
            32'sd2:  return my_pkg::Get2;
            32'sd3:  return my_pkg::Get3;
            default: return my_pkg::GetDefault;
        endcase
    endfunction

    // 100 is the fallback code, not a legal input word.
    function automatic logic is_illegal(input logic signed [31:0] word);
        return !(word >= 32'sd0 && word <= 32'sd3);
    endfunction

    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] value);
        return (&value) ? value : value + CntW'(1);
    endfunction

    assign dec_code    = decode_code(in_data);
    assign dec_invalid = is_illegal(in_data);

    // alive keeps in_ready low until the first edge after reset release.
    always_comb begin
        in_ready = 1'b0;
        if (alive) begin
            case (state)
                EMPTY:   in_ready = 1'b1;
                FULL:    in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept     = in_valid && in_ready;
    assign pop        = vld_p1 && out_ready;
    assign lock_event = StopOnError && accept && dec_invalid && !clear;

    always_comb begin
        vld_nxt   = vld_p1;
        state_nxt = state;
        if (accept) begin
            vld_nxt = 1'b1;
        end else if (pop) begin
            vld_nxt = 1'b0;
        end
        if (lock_event) begin
            state_nxt = LOCKED;
        end else if (state != LOCKED || clear) begin
            state_nxt = vld_nxt ? FULL : EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            alive  <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            state  <= state_nxt;
            alive  <= 1'b1;
            vld_p1 <= vld_nxt;
        end
    end

    // Output stage: loaded only on accept, so it holds under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_code    <= my_pkg::Get0;
            out_invalid <= 1'b0;
        end else if (accept) begin
            out_code    <= dec_code;
            out_invalid <= dec_invalid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt   <= '0;
            invalid_cnt <= '0;
        end else if (clear) begin
            match_cnt   <= '0;
            invalid_cnt <= '0;
        end else if (accept) begin
            if (dec_invalid) begin
                invalid_cnt <= sat_inc(invalid_cnt);
            end else if (dec_code == ExpectWhat) begin
                match_cnt <= sat_inc(match_cnt);
            end
        end
    end

    assign out_valid = vld_p1;
    assign locked    = (state == LOCKED);

endmodule

// File: tb/tb_get_decode.sv
// Bench for get_decode: three parameterisations share one randomized stream and
// are each compared against a transaction-level reference model.
module tb_get_decode;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [31:0] in_data;
    logic               out_ready;
    logic               clear;

    logic         r0, r1, r2, v0, v1, v2, i0, i1, i2, l0, l1, l2;
    my_pkg::get_e c0, c1, c2;
    logic [15:0]  mc0, mc1, ic0, ic1;
    logic [1:0]   mc2, ic2;

    logic        rdy_a  [3];
    logic        ov_a   [3];
    logic [31:0] code_a [3];
    logic        inv_a  [3];
    logic [15:0] mc_a   [3];
    logic [15:0] ic_a   [3];
    logic        lk_a   [3];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model per instance
    int unsigned p_max  [3] = '{32'd65535, 32'd65535, 32'd3};
    int unsigned p_exp  [3] = '{32'd0, 32'd0, 32'd1};
    bit          p_stop [3] = '{1'b0, 1'b1, 1'b0};
    bit          m_alive;
    bit          m_full [3];
    int unsigned m_code [3];
    bit          m_inv  [3];
    int unsigned m_mc   [3];
    int unsigned m_ic   [3];
    bit          m_lock [3];

    always #5 clk = ~clk;

    get_decode u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0), .in_data(in_data),
        .out_valid(v0), .out_ready(out_ready), .out_code(c0), .out_invalid(i0),
        .match_cnt(mc0), .invalid_cnt(ic0), .locked(l0), .clear(clear)
    );

    get_decode #(.StopOnError(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1), .in_data(in_data),
        .out_valid(v1), .out_ready(out_ready), .out_code(c1), .out_invalid(i1),
        .match_cnt(mc1), .invalid_cnt(ic1), .locked(l1), .clear(clear)
    );

    get_decode #(.CntW(2), .ExpectWhat(my_pkg::Get1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r2), .in_data(in_data),
        .out_valid(v2), .out_ready(out_ready), .out_code(c2), .out_invalid(i2),
        .match_cnt(mc2), .invalid_cnt(ic2), .locked(l2), .clear(clear)
    );

    always_comb begin
        rdy_a[0] = r0;  rdy_a[1] = r1;  rdy_a[2] = r2;
        ov_a[0]  = v0;  ov_a[1]  = v1;  ov_a[2]  = v2;
        code_a[0] = c0; code_a[1] = c1; code_a[2] = c2;
        inv_a[0] = i0;  inv_a[1] = i1;  inv_a[2] = i2;
        mc_a[0] = mc0;  mc_a[1] = mc1;  mc_a[2] = {14'd0, mc2};
        ic_a[0] = ic0;  ic_a[1] = ic1;  ic_a[2] = {14'd0, ic2};
        lk_a[0] = l0;   lk_a[1] = l1;   lk_a[2] = l2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_rdy(input int d);
        return m_alive && !m_lock[d] && (!m_full[d] || out_ready);
    endfunction

    task automatic model_reset();
        m_alive = 1'b0;
        for (int d = 0; d < 3; d++) begin
            m_full[d] = 1'b0; m_code[d] = 0; m_inv[d] = 1'b0;
            m_mc[d] = 0; m_ic[d] = 0; m_lock[d] = 1'b0;
        end
    endtask

    task automatic check_reset_values(input string what);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s.d%0d.in_ready", what, d), 32'(rdy_a[d]), 32'd0);
            check($sformatf("%s.d%0d.out_valid", what, d), 32'(ov_a[d]), 32'd0);
            check($sformatf("%s.d%0d.out_code", what, d), code_a[d], 32'd0);
            check($sformatf("%s.d%0d.out_invalid", what, d), 32'(inv_a[d]), 32'd0);
            check($sformatf("%s.d%0d.match_cnt", what, d), 32'(mc_a[d]), 32'd0);
            check($sformatf("%s.d%0d.invalid_cnt", what, d), 32'(ic_a[d]), 32'd0);
            check($sformatf("%s.d%0d.locked", what, d), 32'(lk_a[d]), 32'd0);
        end
    endtask

    // One clock: drive at the falling edge, step the model at the rising edge,
    // compare registered outputs at the next falling edge.
    task automatic cycle(input bit v, input logic [31:0] dat, input bit ordy, input bit clr);
        bit          acc [3];
        bit          pop [3];
        bit          legal;
        int unsigned code;
        in_valid  = v;
        in_data   = dat;
        out_ready = ordy;
        clear     = clr;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d.in_ready", d), 32'(rdy_a[d]), 32'(exp_rdy(d)));
            acc[d] = v && exp_rdy(d);
            pop[d] = m_full[d] && ordy;
        end
        legal = (dat < 32'd4);
        code  = legal ? dat : 32'd100;
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (acc[d]) begin
                m_full[d] = 1'b1; m_code[d] = code; m_inv[d] = !legal;
            end else if (pop[d]) begin
                m_full[d] = 1'b0;
            end
            if (clr) begin
                m_mc[d] = 0; m_ic[d] = 0; m_lock[d] = 1'b0;
            end else if (acc[d]) begin
                if (!legal) begin
                    if (m_ic[d] < p_max[d]) m_ic[d]++;
                    if (p_stop[d]) m_lock[d] = 1'b1;
                end else if (code == p_exp[d]) begin
                    if (m_mc[d] < p_max[d]) m_mc[d]++;
                end
            end
        end
        m_alive = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d.out_valid", d), 32'(ov_a[d]), 32'(m_full[d]));
            if (m_full[d]) begin
                check($sformatf("d%0d.out_code", d), code_a[d], m_code[d]);
                check($sformatf("d%0d.out_invalid", d), 32'(inv_a[d]), 32'(m_inv[d]));
            end
            check($sformatf("d%0d.match_cnt", d), 32'(mc_a[d]), m_mc[d]);
            check($sformatf("d%0d.invalid_cnt", d), 32'(ic_a[d]), m_ic[d]);
            check($sformatf("d%0d.locked", d), 32'(lk_a[d]), 32'(m_lock[d]));
        end
    endtask

    function automatic logic [31:0] pick_word();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'd2;
            3: return 32'd3;
            4: return 32'd255;
            5: return 32'd100;
            6: return $urandom;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic random_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            cycle($urandom_range(0, 3) != 0, pick_word(), $urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        cycle(1'b0, 32'd0, 1'b1, 1'b0);

        // Legal words back-to-back, then illegal ones
        for (int w = 0; w < 4; w++) cycle(1'b1, 32'(w), 1'b1, 1'b0);
        cycle(1'b1, 32'd255, 1'b1, 1'b0);
        cycle(1'b1, 32'd100, 1'b1, 1'b0);
        cycle(1'b1, 32'd7, 1'b1, 1'b0);
        cycle(1'b0, 32'd0, 1'b1, 1'b1);

        // Backpressure with a result loaded, then release
        cycle(1'b1, 32'd2, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b1, 32'd3, 1'b0, 1'b0);
        cycle(1'b1, 32'd3, 1'b1, 1'b0);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);

        // Lock on error: 2, 255, 1; clear; 1 again
        cycle(1'b1, 32'd2, 1'b1, 1'b0);
        cycle(1'b1, 32'd255, 1'b1, 1'b0);
        cycle(1'b1, 32'd1, 1'b1, 1'b0);
        cycle(1'b1, 32'd1, 1'b1, 1'b1);
        cycle(1'b1, 32'd1, 1'b1, 1'b0);

        // Saturation of the narrow counters, clear together with an accept
        cycle(1'b0, 32'd0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) cycle(1'b1, 32'd1, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b1, 32'd9, 1'b1, 1'b0);
        cycle(1'b1, 32'd1, 1'b1, 1'b1);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);

        random_cycles(400);

        // Asynchronous reset while FULL under backpressure
        cycle(1'b1, 32'd2, 1'b0, 1'b0);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_reset_values("midreset");
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        cycle(1'b1, 32'd3, 1'b1, 1'b0);

        random_cycles(300);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1);
    end

endmodule
